// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the LSU return stream and the ALU result stream
// onto the single GPR write port. The LSU always wins. ALU results that lose
// arbitration wait in an in-order FIFO. A query port reports writes that are
// still pending, so decode can detect hazards against them.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_wb_valid,
  output logic                          alu_wb_ready,
  input  logic [AW-1:0]                 alu_wb_addr,
  input  logic [DW-1:0]                 alu_wb_data,
  input  logic                          lsu_wb_valid,
  input  logic [AW-1:0]                 lsu_wb_addr,
  input  logic [DW-1:0]                 lsu_wb_data,
  output logic                          wr_en,
  output logic [AW-1:0]                 wr_addr,
  output logic [DW-1:0]                 wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  input  logic [AW-1:0]                 chk_addr,
  output logic                          chk_hit
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // ALU result buffer storage
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic          fifo_empty;
  logic          alu_acc;
  logic          push;
  logic          pop;
  logic          sel_en;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [PW-1:0] occ_off;

  // Ready depends only on occupancy, so a full buffer never accepts,
  // even in a cycle where it also pops.
  assign fifo_empty   = (cnt == '0);
  assign alu_wb_ready = (cnt < DEPTH_C);
  assign alu_acc      = alu_wb_valid && alu_wb_ready;
  assign fifo_cnt     = cnt;

  // Priority select of the next write: LSU, then FIFO head, then ALU bypass.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else chain leaves one unassigned (which would infer a latch).
    sel_en   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    push     = 1'b0;
    pop      = 1'b0;
    if (lsu_wb_valid) begin
      sel_en   = 1'b1;
      sel_addr = lsu_wb_addr;
      sel_data = lsu_wb_data;
      push     = alu_acc;
    end else if (!fifo_empty) begin
      sel_en   = 1'b1;
      sel_addr = fifo_addr[rd_ptr];
      sel_data = fifo_data[rd_ptr];
      pop      = 1'b1;
      push     = alu_acc;
    end else if (alu_acc) begin
      sel_en   = 1'b1;
      sel_addr = alu_wb_addr;
      sel_data = alu_wb_data;
    end
  end

  // Buffer payload write; the slots that hold data are tracked by the pointers and the count.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset. Occupancy comes only from the
    // pointers and the count, so stale contents are never seen, and the array
    // can be built from plain RAM.
    if (push) begin
      fifo_addr[wr_ptr] <= alu_wb_addr;
      fifo_data[wr_ptr] <= alu_wb_data;
    end
  end

  // Pointer and occupancy bookkeeping; the pointers wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from the values sampled at the edge.
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= sel_en;
      if (sel_en) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  // Hazard query: match against occupied FIFO entries and the write in flight.
  always_comb begin
    chk_hit = wr_en && (wr_addr == chk_addr);
    occ_off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      occ_off = PW'(i) - rd_ptr;
      if (({1'b0, occ_off} < cnt) && (fifo_addr[i] == chk_addr))
        chk_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. The design's outputs are checked against
// expected values worked out by hand.
module tb_wb_arbiter;

  localparam int FIFO_DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic                        clk;
  logic                        rst;
  logic                        alu_wb_valid;
  logic                        alu_wb_ready;
  logic [AW-1:0]               alu_wb_addr;
  logic [DW-1:0]               alu_wb_data;
  logic                        lsu_wb_valid;
  logic [AW-1:0]               lsu_wb_addr;
  logic [DW-1:0]               lsu_wb_data;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [DW-1:0]               wr_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic [AW-1:0]               chk_addr;
  logic                        chk_hit;

  int n_cmp  = 0;
  int n_fail = 0;
  int alu_idx;

  wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_addr  (lsu_wb_addr),
    .lsu_wb_data  (lsu_wb_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .fifo_cnt     (fifo_cnt),
    .chk_addr     (chk_addr),
    .chk_hit      (chk_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    check({tag, "_en"},   32'(wr_en),   32'(en));
    check({tag, "_addr"}, 32'(wr_addr), 32'(a));
    check({tag, "_data"}, wr_data,      d);
  endtask

  initial begin
    rst = 1'b0;
    alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_addr = '0; lsu_wb_data = '0;
    chk_addr = '0;

    // Reset, then 3 idle cycles.
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check_wr("reset", 1'b0, 5'd0, 32'h0);
    check("reset_cnt",   32'(fifo_cnt),     32'd0);
    check("reset_ready", 32'(alu_wb_ready), 32'd1);

    // ALU only, FIFO empty: the result bypasses the FIFO.
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'h1234_5678;
    tick();
    alu_wb_valid = 1'b0;
    check_wr("bypass", 1'b1, 5'd5, 32'h1234_5678);
    check("bypass_cnt", 32'(fifo_cnt), 32'd0);
    tick();
    check_wr("bypass_hold", 1'b0, 5'd5, 32'h1234_5678);

    // Collision: the LSU wins and the ALU result is buffered.
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd3; lsu_wb_data = 32'hAAAA_0000;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd7; alu_wb_data = 32'h0000_BBBB;
    tick();
    lsu_wb_valid = 1'b0; alu_wb_valid = 1'b0;
    check_wr("coll_lsu", 1'b1, 5'd3, 32'hAAAA_0000);
    check("coll_cnt1", 32'(fifo_cnt), 32'd1);
    tick();
    check_wr("coll_alu", 1'b1, 5'd7, 32'h0000_BBBB);
    check("coll_cnt0", 32'(fifo_cnt), 32'd0);
    tick();

    // LSU held for 6 cycles while the ALU offers r1..r5.
    alu_idx = 1;
    for (int k = 0; k < 6; k++) begin
      lsu_wb_valid = 1'b1; lsu_wb_addr = 5'(16 + k); lsu_wb_data = 32'hC000_0000 + k;
      alu_wb_valid = 1'b1; alu_wb_addr = 5'(alu_idx); alu_wb_data = 32'hA000_0000 + alu_idx;
      #1;
      check($sformatf("stream_ready%0d", k), 32'(alu_wb_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
      if (k < 4) alu_idx++;
      check_wr($sformatf("stream_lsu%0d", k), 1'b1, 5'(16 + k), 32'hC000_0000 + k);
    end
    check("stream_full_cnt", 32'(fifo_cnt), 32'd4);
    lsu_wb_valid = 1'b0;
    alu_wb_addr = 5'd5; alu_wb_data = 32'hA000_0005;
    #1;
    check("drain_ready_full", 32'(alu_wb_ready), 32'd0);
    tick();
    check_wr("drain_r1", 1'b1, 5'd1, 32'hA000_0001);
    check("drain_cnt1", 32'(fifo_cnt), 32'd3);
    check("drain_ready_open", 32'(alu_wb_ready), 32'd1);
    tick();
    alu_wb_valid = 1'b0;
    check_wr("drain_r2", 1'b1, 5'd2, 32'hA000_0002);
    check("drain_cnt2", 32'(fifo_cnt), 32'd3);
    for (int j = 3; j <= 5; j++) begin
      tick();
      check_wr($sformatf("drain_r%0d", j), 1'b1, 5'(j), 32'hA000_0000 + j);
      check($sformatf("drain_cnt_r%0d", j), 32'(fifo_cnt), 32'(5 - j));
    end
    tick();
    check("drain_idle", 32'(wr_en), 32'd0);

    // Hazard query.
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd1; lsu_wb_data = 32'h11;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd9; alu_wb_data = 32'h99;
    tick();
    lsu_wb_valid = 1'b0; alu_wb_valid = 1'b0;
    chk_addr = 5'd9;  #1; check("haz_fifo9",   32'(chk_hit), 32'd1);
    chk_addr = 5'd10; #1; check("haz_miss10",  32'(chk_hit), 32'd0);
    chk_addr = 5'd1;  #1; check("haz_wr1",     32'(chk_hit), 32'd1);
    tick();
    chk_addr = 5'd9;  #1;
    check_wr("haz_r9", 1'b1, 5'd9, 32'h99);
    check("haz_wr9", 32'(chk_hit), 32'd1);
    tick();
    check("haz_after", 32'(chk_hit), 32'd0);

    // Simultaneous push and pop with fifo_cnt=2.
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd30; lsu_wb_data = 32'h30;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd11; alu_wb_data = 32'hB11;
    tick();
    lsu_wb_addr = 5'd31; lsu_wb_data = 32'h31;
    alu_wb_addr = 5'd12; alu_wb_data = 32'hB12;
    tick();
    check("pp_cnt_pre", 32'(fifo_cnt), 32'd2);
    lsu_wb_valid = 1'b0;
    alu_wb_addr = 5'd13; alu_wb_data = 32'hB13;
    tick();
    alu_wb_valid = 1'b0;
    check_wr("pp_head", 1'b1, 5'd11, 32'hB11);
    check("pp_cnt_same", 32'(fifo_cnt), 32'd2);
    tick();
    check_wr("pp_r12", 1'b1, 5'd12, 32'hB12);
    tick();
    check_wr("pp_r13_last", 1'b1, 5'd13, 32'hB13);
    check("pp_cnt_end", 32'(fifo_cnt), 32'd0);
    tick();

    // Wrap-around: 10 push/pop pairs with one entry resident; GPR 0 included.
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd31; lsu_wb_data = 32'h5555;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 32'hD000_0000;
    tick();
    lsu_wb_valid = 1'b0;
    chk_addr = 5'd0; #1;
    check("wrap_gpr0_hit", 32'(chk_hit), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      alu_wb_addr = 5'(i); alu_wb_data = 32'hD000_0000 + i;
      tick();
      check_wr($sformatf("wrap%0d", i), 1'b1, 5'(i - 1), 32'hD000_0000 + i - 1);
      check($sformatf("wrap_cnt%0d", i), 32'(fifo_cnt), 32'd1);
    end
    alu_wb_valid = 1'b0;
    tick();
    check_wr("wrap_last", 1'b1, 5'd10, 32'hD000_000A);
    check("wrap_cnt_end", 32'(fifo_cnt), 32'd0);
    tick();

    // Reset asserted mid-burst.
    lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd20; lsu_wb_data = 32'h20;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd21; alu_wb_data = 32'h21;
    tick();
    lsu_wb_addr = 5'd22; lsu_wb_data = 32'h22;
    alu_wb_addr = 5'd23; alu_wb_data = 32'h23;
    tick();
    check("mid_cnt_pre", 32'(fifo_cnt), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_wr("mid_rst", 1'b0, 5'd0, 32'h0);
    check("mid_rst_cnt",   32'(fifo_cnt),     32'd0);
    check("mid_rst_ready", 32'(alu_wb_ready), 32'd1);
    chk_addr = 5'd21; #1;
    check("mid_rst_hit", 32'(chk_hit), 32'd0);
    lsu_wb_valid = 1'b0; alu_wb_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_wr0", 32'(wr_en), 32'd0);
    tick();
    check("post_rst_wr1", 32'(wr_en), 32'd0);
    check("post_rst_cnt", 32'(fifo_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
